// File: rtl/scanout_pkg.sv
// Shared VGA 640x480@60 timing constants and coordinate types for the scanout block.
package scanout_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [$clog2(VGA_H_TOTAL)-1:0] hcoord_t;
  typedef logic [$clog2(VGA_V_TOTAL)-1:0] vcoord_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel divider plus x/y raster counters; sync and blank decoded from the current position.
module vga_timing
  import scanout_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int CLK_DIV  = 2,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int XW      = $clog2(H_TOTAL),
  localparam int YW      = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          pix_en,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          x_last,
  output logic          y_last,
  output logic          hsync_n,
  output logic          vsync_n,
  output logic          blank
);

  localparam int DW = $clog2(CLK_DIV);

  logic [DW-1:0] div;

  assign pix_en = (div == DW'(CLK_DIV - 1));
  assign x_last = (x == XW'(H_TOTAL - 1));
  assign y_last = (y == YW'(V_TOTAL - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div <= '0;
      x   <= '0;
      y   <= '0;
    end else begin
      div <= pix_en ? '0 : div + 1'b1;
      if (pix_en) begin
        if (x_last) begin
          x <= '0;
          y <= y_last ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

  assign hsync_n = !((x >= XW'(H_ACTIVE + H_FP)) && (x < XW'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync_n = !((y >= YW'(V_ACTIVE + V_FP)) && (y < YW'(V_ACTIVE + V_FP + V_SYNC)));
  assign blank   = (x >= XW'(H_ACTIVE)) || (y >= YW'(V_ACTIVE));

endmodule

// File: rtl/framebuffer_scanout.sv
// Raster scanout from the framebuffer SRAM with integer pixel scaling and 1-pixel output alignment.
// Build option SCANOUT_DOUBLE_BUFFER_EN adds a second page selected by buffer_sel at vblank.
module framebuffer_scanout
  import scanout_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int CLK_DIV  = 2,
  parameter int FB_SHIFT = 2,
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 15
) (
  input  logic               clk,
  input  logic               rst_async,
  output logic [A_WIDTH-1:0] read_addr,
  input  logic [D_WIDTH-1:0] read_data,
  output logic [D_WIDTH-1:0] rgb,
  output logic               hsync_n,
  output logic               vsync_n,
  output logic               blank,
  output logic               frame_start,
  input  logic               buffer_sel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int FB_W    = H_ACTIVE >> FB_SHIFT;
  localparam int STEP    = 1 << FB_SHIFT;

  logic          pix_en;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          x_last;
  logic          y_last;
  logic          raw_hsync_n;
  logic          raw_vsync_n;
  logic          raw_blank;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .CLK_DIV(CLK_DIV)
  ) u_timing (
    .clk     (clk),
    .rst     (rst_async),
    .pix_en  (pix_en),
    .x       (x),
    .y       (y),
    .x_last  (x_last),
    .y_last  (y_last),
    .hsync_n (raw_hsync_n),
    .vsync_n (raw_vsync_n),
    .blank   (raw_blank)
  );

  logic [A_WIDTH-1:0] col;
  logic [A_WIDTH-1:0] col_nxt;
  logic [A_WIDTH-1:0] row_base;
  logic [A_WIDTH-1:0] row_base_nxt;
  logic [A_WIDTH-1:0] page_off;
  logic               cell_end_x;
  logic               cell_end_y;

  // Address terms are computed for the pixel about to start, so read_addr
  // is already valid on the first clk of that pixel.
  assign cell_end_x = ((x & XW'(STEP - 1)) == XW'(STEP - 1));
  assign cell_end_y = ((y & YW'(STEP - 1)) == YW'(STEP - 1));

  always_comb begin
    col_nxt      = col;
    row_base_nxt = row_base;
    if (x_last) begin
      col_nxt = '0;
      if (y_last)
        row_base_nxt = '0;
      else if ((y < YW'(V_ACTIVE - 1)) && cell_end_y)
        row_base_nxt = row_base + A_WIDTH'(FB_W);
    end else if ((y < YW'(V_ACTIVE)) && (x < XW'(H_ACTIVE - 1)) && cell_end_x) begin
      col_nxt = col + 1'b1;
    end
  end

`ifdef SCANOUT_DOUBLE_BUFFER_EN
  localparam int FB_WORDS = FB_W * (V_ACTIVE >> FB_SHIFT);

  logic page_q;

  // Page changes only at the start of vblank, never mid-picture.
  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async)
      page_q <= 1'b0;
    else if (frame_start)
      page_q <= buffer_sel;
  end

  assign page_off = page_q ? A_WIDTH'(FB_WORDS) : '0;
`else
  logic unused_buffer_sel;

  assign unused_buffer_sel = buffer_sel;
  assign page_off          = '0;
`endif

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      col         <= '0;
      row_base    <= '0;
      read_addr   <= '0;
      rgb         <= '0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && x_last && (y == YW'(V_ACTIVE - 1));
      if (pix_en) begin
        col       <= col_nxt;
        row_base  <= row_base_nxt;
        read_addr <= row_base_nxt + col_nxt + page_off;
        // read_data now holds the word for the pixel that is ending here.
        rgb       <= raw_blank ? '0 : read_data;
        hsync_n   <= raw_hsync_n;
        vsync_n   <= raw_vsync_n;
        blank     <= raw_blank;
      end
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout on a reduced raster geometry with a 1-clk-latency SRAM model.
module tb_framebuffer_scanout;

  localparam int CD = 2;
  localparam int HA = 32, HF = 4, HS = 8, HB = 4;
  localparam int VA = 16, VF = 2, VS = 2, VB = 3;
  localparam int FS = 2, DW = 8, AW = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FBW = HA >> FS;
  localparam int FBWORDS = FBW * (VA >> FS);
  localparam int FRAME = HT * VT * CD;
`ifdef SCANOUT_DOUBLE_BUFFER_EN
  localparam bit PAGED = 1'b1;
`else
  localparam bit PAGED = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_async;
  logic [AW-1:0] read_addr;
  logic [DW-1:0] read_data;
  logic [DW-1:0] rgb;
  logic          hsync_n, vsync_n, blank, frame_start;
  logic          buffer_sel;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int errors = 0;
  int n = 0;
  int phase = 1;
  int model_page = 0;
  int hs_low = 0;
  int fs_count = 0;
  int fs_prev = -1;
  int fs_gap = 0;
  bit table_on = 1'b0;

  typedef struct {
    int n;
    bit chk_addr;
    int addr;
    bit hs;
    bit vs;
    bit bl;
    bit fs;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  always @(posedge clk) read_data <= mem[read_addr];

  framebuffer_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .CLK_DIV(CD), .FB_SHIFT(FS), .D_WIDTH(DW), .A_WIDTH(AW)
  ) dut (
    .clk         (clk),
    .rst_async   (rst_async),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .rgb         (rgb),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .blank       (blank),
    .frame_start (frame_start),
    .buffer_sel  (buffer_sel)
  );

  function automatic int fb_addr(input int x, input int y);
    return ((y >> FS) * FBW + (x >> FS) + model_page * FBWORDS) % (1 << AW);
  endfunction

  task automatic chk(input string what, input int at, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d got %0d expected %0d", what, at, act, exp);
    end
  endtask

  task automatic add_vec(input int vn, input bit ca, input int a, input bit hs, input bit vs,
                         input bit bl, input bit fs);
    vec_t v;
    v.n = vn; v.chk_addr = ca; v.addr = a; v.hs = hs; v.vs = vs; v.bl = bl; v.fs = fs;
    vecs.push_back(v);
  endtask

  // Expected behaviour from raster position: counters at pixel p, outputs show pixel p-1.
  task automatic check_cycle(input int cn, output bit fs_exp);
    int p, x, y, q, xq, yq;
    bit bl, hs, vs;
    int rgb_exp;
    p = cn / CD;
    x = p % HT;
    y = (p / HT) % VT;
    if (x < HA && y < VA)
      chk("read_addr", cn, 32'(read_addr), fb_addr(x, y));
    if (p == 0) begin
      bl = 1'b1; hs = 1'b1; vs = 1'b1; rgb_exp = 0;
    end else begin
      q  = p - 1;
      xq = q % HT;
      yq = (q / HT) % VT;
      bl = (xq >= HA) || (yq >= VA);
      hs = !(xq >= HA + HF && xq < HA + HF + HS);
      vs = !(yq >= VA + VF && yq < VA + VF + VS);
      rgb_exp = bl ? 0 : int'(mem[fb_addr(xq, yq)]);
    end
    fs_exp = (x == 0) && (y == VA) && (cn % CD == 0);
    chk("rgb", cn, 32'(rgb), rgb_exp);
    chk("hsync_n", cn, 32'(hsync_n), 32'(hs));
    chk("vsync_n", cn, 32'(vsync_n), 32'(vs));
    chk("blank", cn, 32'(blank), 32'(bl));
    chk("frame_start", cn, 32'(frame_start), 32'(fs_exp));
    if (table_on) begin
      foreach (vecs[i]) begin
        if (vecs[i].n == cn) begin
          if (vecs[i].chk_addr)
            chk("tbl_read_addr", cn, 32'(read_addr), vecs[i].addr);
          chk("tbl_hsync_n", cn, 32'(hsync_n), 32'(vecs[i].hs));
          chk("tbl_vsync_n", cn, 32'(vsync_n), 32'(vecs[i].vs));
          chk("tbl_blank", cn, 32'(blank), 32'(vecs[i].bl));
          chk("tbl_frame_start", cn, 32'(frame_start), 32'(vecs[i].fs));
        end
      end
      if (cn < HT * CD && hsync_n === 1'b0) hs_low++;
    end
    if (frame_start === 1'b1) begin
      if (fs_prev >= 0) fs_gap = cn - fs_prev;
      fs_prev = cn;
      fs_count++;
    end
  endtask

  task automatic run(input int n_end);
    bit fs_exp;
    while (n <= n_end) begin
      #1;
      check_cycle(n, fs_exp);
      if (fs_exp) model_page = PAGED ? int'(buffer_sel) : 0;
      if (phase == 2 && n > FRAME + CD && (n % CD) != 0 && $urandom_range(0, 199) == 0)
        buffer_sel = ~buffer_sel;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_read_addr"}, n, 32'(read_addr), 0);
    chk({tag, "_rgb"}, n, 32'(rgb), 0);
    chk({tag, "_hsync_n"}, n, 32'(hsync_n), 1);
    chk({tag, "_vsync_n"}, n, 32'(vsync_n), 1);
    chk({tag, "_blank"}, n, 32'(blank), 1);
    chk({tag, "_frame_start"}, n, 32'(frame_start), 0);
  endtask

  initial begin
    // n: clk index after release; addr, hsync_n, vsync_n, blank, frame_start
    add_vec(0,    1, 0,  1, 1, 1, 0);
    add_vec(1,    1, 0,  1, 1, 1, 0);
    add_vec(2,    1, 0,  1, 1, 0, 0);
    add_vec(8,    1, 1,  1, 1, 0, 0);
    add_vec(62,   1, 7,  1, 1, 0, 0);
    add_vec(64,   0, 0,  1, 1, 0, 0);
    add_vec(66,   0, 0,  1, 1, 1, 0);
    add_vec(74,   0, 0,  0, 1, 1, 0);
    add_vec(88,   0, 0,  0, 1, 1, 0);
    add_vec(90,   0, 0,  1, 1, 1, 0);
    add_vec(96,   1, 0,  1, 1, 1, 0);
    add_vec(768,  1, 16, 1, 1, 1, 0);
    add_vec(770,  1, 16, 1, 1, 0, 0);
    add_vec(1502, 1, 31, 1, 1, 0, 0);
    add_vec(1536, 0, 0,  1, 1, 1, 1);
    add_vec(1537, 0, 0,  1, 1, 1, 0);
    add_vec(1730, 0, 0,  1, 0, 1, 0);
    add_vec(1920, 0, 0,  1, 0, 1, 0);
    add_vec(1922, 0, 0,  1, 1, 1, 0);
    add_vec(2208, 1, 0,  1, 1, 1, 0);
    add_vec(2210, 1, 0,  1, 1, 0, 0);

    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    mem[0] = 8'hA5;

    rst_async  = 1'b1;
    buffer_sel = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("in_reset");

    // Phase 1: three-plus frames from a clean release, stopping mid-picture.
    rst_async = 1'b0;
    table_on  = 1'b1;
    run(3 * FRAME + (10 * HT + 20) * CD);
    chk("hsync_low_clks", n, hs_low, HS * CD);
    chk("frame_start_count_p1", n, fs_count, 3);
    chk("frame_start_period", n, fs_gap, FRAME);

    // Mid-picture reset must take effect inside the same clk.
    @(posedge clk);
    #1;
    chk("pre_reset_blank", n, 32'(blank), 0);
    rst_async = 1'b1;
    #1;
    check_reset_values("mid_reset");
    repeat (2) @(negedge clk);
    check_reset_values("mid_reset_held");

    // Phase 2: restart from (0,0); page request made before the first vblank.
    phase      = 2;
    table_on   = 1'b0;
    model_page = 0;
    buffer_sel = 1'b1;
    fs_count   = 0;
    fs_prev    = -1;
    n          = 0;
    rst_async  = 1'b0;
    run(3 * FRAME);
    chk("frame_start_count_p2", n, fs_count, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/framebuffer_scanout.md
Name: framebuffer_scanout

Overview:
- Downstream consumer of the dual-port framebuffer SRAM (port B reads).
- Generates VGA 640x480@60 timing and issues framebuffer read addresses in raster order, with integer pixel scaling.
- Accounts for the SRAM's 1-clk registered read latency and drives aligned rgb/hsync_n/vsync_n to the DAC pins.
- Also emits a frame_start pulse so the CPU can sync to vblank.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, clk cycles per pixel (≥2)
- FB_SHIFT, 2, scale factor log2 (4x4 screen pixels per fb word)
- D_WIDTH, 8, framebuffer word / rgb width
- A_WIDTH, 15, framebuffer address width

Ports:
- clk  in  1  system clock
- rst_async  in  1  asynchronous reset, active-high
- read_addr  out  A_WIDTH  to SRAM read_addr_b
- read_data  in  D_WIDTH  from SRAM read_b (valid 1 clk after address)
- rgb  out  D_WIDTH  pixel to DAC; 0 when blanked
- hsync_n  out  1  horizontal sync, active-low
- vsync_n  out  1  vertical sync, active-low
- blank  out  1  high outside active area
- frame_start  out  1  1-clk pulse at first clk of line V_ACTIVE (start of vblank)
- buffer_sel  in  1  page select (only with optional feature)

Behaviour:
- Reset (async assert, sync release):
  - all counters 0; read_addr=0, rgb=0, hsync_n=1, vsync_n=1, blank=1, frame_start=0.
  - First pixel after release is x=0,y=0.
- Pixel strobe: div counter 0..CLK_DIV-1; pix_en high when div==CLK_DIV-1. Everything below advances only on pix_en.
- Counters:
  - x 0..H_TOTAL-1 (H_TOTAL=sum of H params); x wraps and y increments at x==H_TOTAL-1.
  - y wraps to 0 at y==V_TOTAL-1.
- Address generation (no multiplier), with FB_W = H_ACTIVE>>FB_SHIFT:
  - row_base register: +FB_W when y wraps past a multiple-of-2^FB_SHIFT boundary inside active; reset to 0 at y wrap.
  - col register: +1 every 2^FB_SHIFT active pixels.
  - read_addr = row_base + col, registered, updated on pix_en. Value is don't-care but stable during blanking.
- Pipeline: stage 0 = counters/address; stage 1 = capture read_data.
  - Outputs register on the next pix_en, so rgb/hsync_n/vsync_n/blank lag counters by exactly one pixel.
  - Syncs and blank are delayed by the same register so all four outputs stay aligned.
- Sync windows:
  - hsync_n=0 for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync_n=0 for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- blank = (x≥H_ACTIVE)|(y≥V_ACTIVE). rgb forced to 0 when blank.
- frame_start: single clk (not pixel) pulse on the pix_en where y becomes V_ACTIVE and x=0.
- Widths: x,y sized by $clog2 of totals; address arithmetic A_WIDTH, wraps modulo 2^A_WIDTH.
- Reset mid-frame: immediate return to reset values; no partial pulse on frame_start.

Optional Feature:
- Macro: SCANOUT_DOUBLE_BUFFER_EN.
- Defined:
  - buffer_sel is sampled into page_q on the frame_start pulse.
  - read_addr += page_q ? FB_WORDS : 0, where FB_WORDS = FB_W*(V_ACTIVE>>FB_SHIFT).
  - page_q resets to 0.
  - A_WIDTH must hold 2*FB_WORDS.
- Undefined: buffer_sel ignored (port still present); single page at address 0.

Decomposition:
- Package scanout_pkg:
  - VGA 640x480 timing constants.
  - derived H_TOTAL/V_TOTAL.
  - typedef for coordinate counters.
- Sub-module vga_timing: div/x/y counters, sync/blank/pix_en generation.
- Top handles address generation, pipeline alignment and the optional page logic.

Test Plan:
- Reset release: first 2 clks read_addr=0, hsync_n=vsync_n=1, blank=1, rgb=0; first pixel output has blank=0 with rgb equal to SRAM model word 0 (value 8'hA5).
- Line 0 scan: read_addr holds 0 for x=0..3, 1 for x=4..7, reaches 159 at x=636; rgb follows SRAM model with exactly 1-pixel lag.
- Line sequencing: lines 0..3 reuse base 0; line 4 starts at addr 160; line 479 starts at 119*160=19040.
- Sync/blank: hsync_n low for exactly 96 pixels (192 clks) starting 16 pixels after blank rises; vsync_n low for 2 lines starting at line 490; frame_start pulses once per 800*525*2 clks.
- Mid-frame reset (at y=200, x=300): outputs go to reset values within the same clk; after release scan restarts at addr 0, y=0.
- With SCANOUT_DOUBLE_BUFFER_EN: set buffer_sel=1 mid-frame; addresses stay in page 0 until frame_start, then the next frame's first address is 19200.
